// File: rtl/led_pattern_gen.sv
// led_pattern_gen: N_LEDS-wide LED driver with a programmable prescaler and
// four runtime-selectable patterns (binary count, chase, bounce, PWM dim).
// The step output pulses for one cycle after each pattern step.

module led_pattern_gen #(
    parameter int N_LEDS    = 4,
    parameter int DIV_WIDTH = 24,
    parameter int PWM_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [PWM_BITS-1:0]  duty,
    output logic [N_LEDS-1:0]    led,
    output logic                 step
);

    typedef enum logic [1:0] {
        MODE_BIN    = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_PWM    = 2'd3
    } mode_t;

    localparam int                PW       = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam logic [PW-1:0]     POS_LAST = PW'(N_LEDS - 1);
    localparam logic [N_LEDS-1:0] LED_ONE  = N_LEDS'(1);

    mode_t                 mode_q;
    mode_t                 mode_in;
    logic [DIV_WIDTH-1:0]  pre_cnt;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [N_LEDS-1:0]     pat;      // binary count value or chase vector
    logic [PW-1:0]         pos;      // bounce position
    logic                  dir_up;   // bounce direction

    logic                  change;
    logic                  tick;
    logic                  pwm_on;
    logic [N_LEDS-1:0]     pat_step;
    logic [PW-1:0]         pos_step;
    logic                  dir_step;

    assign mode_in = mode_t'(mode);

    // Mode-change / tick decode and the next pattern state for a step
    always_comb begin
        change   = en && (mode_in != mode_q);
        tick     = en && !change && (pre_cnt >= div);
        pwm_on   = (pwm_cnt < duty);
        pat_step = pat;
        pos_step = pos;
        dir_step = dir_up;
        case (mode_q)
            MODE_BIN:   pat_step = pat + N_LEDS'(1);
            // rotate left; for a single LED this degenerates to identity
            MODE_CHASE: pat_step = (pat << 1) | (pat >> (N_LEDS - 1));
            MODE_BOUNCE: begin
                // direction flips at the end while moving away, so the end LED
                // is lit for a single step period
                if (N_LEDS > 1) begin
                    if (dir_up) begin
                        if (pos == POS_LAST) begin
                            dir_step = 1'b0;
                            pos_step = pos - PW'(1);
                        end else begin
                            pos_step = pos + PW'(1);
                        end
                    end else begin
                        if (pos == '0) begin
                            dir_step = 1'b1;
                            pos_step = pos + PW'(1);
                        end else begin
                            pos_step = pos - PW'(1);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Prescaler, PWM counter, pattern state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_BIN;
            pre_cnt <= '0;
            pwm_cnt <= '0;
            pat     <= '0;
            pos     <= '0;
            dir_up  <= 1'b1;
            led     <= '0;
            step    <= 1'b0;
        end else if (!en) begin
            step <= 1'b0;
        end else if (change) begin
            mode_q  <= mode_in;
            pre_cnt <= '0;
            step    <= 1'b0;
            case (mode_in)
                MODE_BIN: begin
                    pat <= '0;
                    led <= '0;
                end
                MODE_CHASE: begin
                    pat <= LED_ONE;
                    led <= LED_ONE;
                end
                MODE_BOUNCE: begin
                    pos    <= '0;
                    dir_up <= 1'b1;
                    led    <= LED_ONE;
                end
                MODE_PWM: led <= {N_LEDS{pwm_on}};
                default: ;
            endcase
        end else begin
            step    <= tick;
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            pre_cnt <= tick ? '0 : pre_cnt + DIV_WIDTH'(1);
            if (mode_q == MODE_PWM) begin
                led <= {N_LEDS{pwm_on}};
            end else if (tick) begin
                pat    <= pat_step;
                pos    <= pos_step;
                dir_up <= dir_step;
                led    <= (mode_q == MODE_BOUNCE) ? (LED_ONE << pos_step) : pat_step;
            end
        end
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised successor to the single-mode blinky LED driver.
- Drives N_LEDS outputs from one clock through a runtime-programmable prescaler. Four runtime-selectable patterns: binary count, one-hot chase, bounce, and PWM dim.
- Sits between the board clock input buffer and the LED output buffers of the top level. Exposes a step strobe for simulation and debug.

Parameters:
N_LEDS, 4, number of LED outputs (1..32)
DIV_WIDTH, 24, width of prescaler divisor and counter
PWM_BITS, 8, width of PWM counter and duty input

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  1 = run; 0 = freeze prescaler, PWM counter, pattern and outputs
mode  input  2  0 binary, 1 chase, 2 bounce, 3 PWM
div  input  DIV_WIDTH  pattern step period = div+1 enabled cycles
duty  input  PWM_BITS  PWM on-count, used in mode 3 only
led  output  N_LEDS  registered LED drive, 1 = on
step  output  1  registered one-cycle pulse, high in the cycle after each pattern step

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs: led=0, step=0.
  - State: pre_cnt=0, pwm_cnt=0, mode_q=0, pattern state=0, bounce dir=up.
- Prescaler:
  - When en=1 and pre_cnt>=div: tick=1 and pre_cnt<=0. Otherwise pre_cnt increments.
  - ">=" is required: lowering div below the current count causes a tick on the next enabled cycle, with no 2^DIV_WIDTH wrap.
  - div=0 gives a tick every enabled cycle.
- Mode change:
  - If mode != mode_q on an enabled cycle, that edge does the following and nothing else: mode_q<=mode, pre_cnt<=0, pattern loads its initial state, and no step is issued.
  - Initial states: binary=0; chase=one-hot bit0; bounce=position 0 with dir up.
  - led shows the new initial pattern on that same edge. Mode 3 has no initial pattern; led follows the PWM compare.
- Mode 0, binary: on tick, cnt<=cnt+1 modulo 2^N_LEDS; led<=next cnt.
- Mode 1, chase: on tick, rotate left by 1; bit N_LEDS-1 wraps to bit0. Exactly one LED is on at all times.
- Mode 2, bounce:
  - One LED on at position p. On tick:
    - dir up and p<N_LEDS-1: p+1.
    - dir up and p=N_LEDS-1: dir<=down, p-1.
    - Symmetric at position 0.
  - The end LED is lit for exactly one step period (no double dwell).
  - N_LEDS=1: p stays 0 and the LED is always on.
- Mode 3, PWM:
  - pwm_cnt increments every enabled cycle, wrapping at 2^PWM_BITS.
  - Every LED <= (pwm_cnt < duty).
  - duty=0 gives always off; duty=2^PWM_BITS-1 gives on for 255 of 256 cycles at the default width.
  - The prescaler still runs and step still pulses; the pattern does not change.
- step: step<=tick on every edge (forced 0 when en=0). Width is exactly 1 cycle; with div=0 it is continuously high.
- en=0: every register holds, including led; step<=0. A mode change is not applied until en=1.
- Latency:
  - led updates on the same edge that consumes the tick.
  - step is high during the following cycle.
  - From a mode change to the first step of the new mode: div+1 enabled cycles after the change edge.

Test Plan:
1. Reset then en=1, mode=0, N_LEDS=4, div=3 -> led steps 0,1,2,…,15,0 every 4 cycles; step pulses 1 cycle wide at period 4; the 0→1 transition occurs 4 cycles after en rises.
2. mode=1, div=0 -> led sequence 0001,0010,0100,1000,0001 on consecutive cycles; step held high; never 0 or more than one bit set.
3. mode=2, div=1 -> led 0001,0010,0100,1000,0100,0010,0001,0010, each held 2 cycles; direction reverses at both ends without repeating an end value.
4. mode=3, duty=64, PWM_BITS=8 -> over 256 cycles each LED is high exactly 64 cycles, all LEDs identical. duty=0 gives 0 high cycles; duty=255 gives 255 high cycles.
5. While in mode 0 at led=5, change mode to 1 mid-period with div=9 -> next edge gives led=0001, pre_cnt=0, no step; first rotate occurs 10 cycles later. Separately, drop div from 9 to 2 while pre_cnt=7 -> tick on the next enabled cycle.
6. en=0 for 20 cycles mid-pattern -> led and step frozen (step=0), and the pattern resumes from the same value. Assert rst_n low asynchronously between clock edges -> led=0 and step=0 immediately; after release, mode 0 restarts counting from 0.
